// File: rtl/uart_alu_frame_ctrl_pkg.sv
// Shared definitions for the UART/ALU framed command controller:
// header codes, FSM encoding and byte-count helpers.
package uart_alu_frame_ctrl_pkg;

    localparam logic [7:0] HDR_A    = 8'h08;
    localparam logic [7:0] HDR_B    = 8'h10;
    localparam logic [7:0] HDR_OP   = 8'h20;
    localparam logic [7:0] HDR_READ = 8'h40;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_TX_LOAD = 2'd2,
        ST_TX_WAIT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SEL_A  = 2'd0,
        SEL_B  = 2'd1,
        SEL_OP = 2'd2
    } sel_t;

    // Number of UART characters per operand/result word.
    function automatic int unsigned byte_count(input int unsigned nb_data,
                                               input int unsigned nb_byte);
        return nb_data / nb_byte;
    endfunction

    // Counter width able to index n bytes, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte cycle counter: synchronous clear, count enable and a
// combinational terminal-count flag at TIMEOUT-1.
module uart_frame_timer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc_c
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign tc_c = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/uart_alu_frame_ctrl.sv
// Framed command controller: assembles ALU operands/opcode from header-tagged
// UART frames and streams the snapshotted ALU result back on READ.
module uart_alu_frame_ctrl #(
    parameter int unsigned NB_BYTE = 8,
    parameter int unsigned NB_DATA = 16,
    parameter int unsigned NB_OP   = 6,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic               o_valid,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_frame_err,
    output logic               o_busy
);
    import uart_alu_frame_ctrl_pkg::*;

    localparam int unsigned NBYTES = byte_count(NB_DATA, NB_BYTE);
    localparam int unsigned CNT_W  = cnt_width(NBYTES);
    localparam int unsigned SW     = (NBYTES > 1) ? (NB_DATA - NB_BYTE) : 1;

    state_t             state, state_nxt;
    sel_t               sel, sel_nxt;
    logic [SW-1:0]      staging, staging_nxt;
    logic [CNT_W-1:0]   byte_cnt, byte_cnt_nxt;
    logic [NB_DATA-1:0] tx_shift, tx_shift_nxt;
    logic [CNT_W-1:0]   tx_idx, tx_idx_nxt;
    logic [NB_DATA-1:0] data_a_nxt, data_b_nxt;
    logic [NB_OP-1:0]   op_nxt;
    logic [NB_BYTE-1:0] tx_data_nxt;
    logic               valid_nxt, tx_start_nxt, frame_err_nxt;
    logic [NB_DATA-1:0] shifted_c;
    logic               hdr_a_c, hdr_b_c, hdr_op_c, hdr_read_c;
    logic               last_c, tx_last_c, timeout_c;

    assign hdr_a_c    = (i_rx_data == NB_BYTE'(HDR_A));
    assign hdr_b_c    = (i_rx_data == NB_BYTE'(HDR_B));
    assign hdr_op_c   = (i_rx_data == NB_BYTE'(HDR_OP));
    assign hdr_read_c = (i_rx_data == NB_BYTE'(HDR_READ));
    assign last_c     = (sel == SEL_OP) || (byte_cnt == CNT_W'(NBYTES - 1));
    assign tx_last_c  = (tx_idx == CNT_W'(NBYTES - 1));

    // Staging holds earlier bytes; the incoming byte lands in the MSB slot.
    generate
        if (NBYTES > 1) begin : g_multi
            assign shifted_c = {i_rx_data, staging};
        end else begin : g_single
            assign shifted_c = i_rx_data;
        end
    endgenerate

    // A byte arriving in the timeout cycle clears the timer and so suppresses it.
    uart_frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .i_rst_n(i_rst_n),
        .clear  (i_rx_done || (state != ST_PAYLOAD)),
        .enable ((state == ST_PAYLOAD) && !i_rx_done),
        .tc_c   (timeout_c)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_rx_done) begin
                    if (hdr_a_c || hdr_b_c || hdr_op_c) state_nxt = ST_PAYLOAD;
                    else if (hdr_read_c)               state_nxt = ST_TX_LOAD;
                end
            end
            ST_PAYLOAD: begin
                if ((i_rx_done && last_c) || timeout_c) state_nxt = ST_IDLE;
            end
            ST_TX_LOAD: state_nxt = ST_TX_WAIT;
            ST_TX_WAIT: begin
                if (i_tx_done) state_nxt = tx_last_c ? ST_IDLE : ST_TX_LOAD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_nxt       = sel;
        staging_nxt   = staging;
        byte_cnt_nxt  = byte_cnt;
        tx_shift_nxt  = tx_shift;
        tx_idx_nxt    = tx_idx;
        data_a_nxt    = o_data_a;
        data_b_nxt    = o_data_b;
        op_nxt        = o_op;
        tx_data_nxt   = o_tx_data;
        valid_nxt     = 1'b0;
        tx_start_nxt  = 1'b0;
        frame_err_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_rx_done) begin
                    staging_nxt  = '0;
                    byte_cnt_nxt = '0;
                    if (hdr_a_c) begin
                        sel_nxt = SEL_A;
                    end else if (hdr_b_c) begin
                        sel_nxt = SEL_B;
                    end else if (hdr_op_c) begin
                        sel_nxt = SEL_OP;
                    end else if (hdr_read_c) begin
                        tx_data_nxt  = i_alu_result[NB_BYTE-1:0];
                        tx_shift_nxt = NB_DATA'(i_alu_result >> NB_BYTE);
                        tx_idx_nxt   = '0;
                        tx_start_nxt = 1'b1;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (i_rx_done) begin
                    staging_nxt  = SW'(shifted_c >> NB_BYTE);
                    byte_cnt_nxt = byte_cnt + CNT_W'(1);
                    if (last_c) begin
                        case (sel)
                            SEL_A:   data_a_nxt = shifted_c;
                            SEL_B:   data_b_nxt = shifted_c;
                            default: begin
                                op_nxt    = i_rx_data[NB_OP-1:0];
                                valid_nxt = 1'b1;
                            end
                        endcase
                    end
                end else if (timeout_c) begin
                    staging_nxt   = '0;
                    frame_err_nxt = 1'b1;
                end
            end
            ST_TX_WAIT: begin
                if (i_tx_done && !tx_last_c) begin
                    tx_idx_nxt   = tx_idx + CNT_W'(1);
                    tx_data_nxt  = tx_shift[NB_BYTE-1:0];
                    tx_shift_nxt = NB_DATA'(tx_shift >> NB_BYTE);
                    tx_start_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sel         <= SEL_A;
            staging     <= '0;
            byte_cnt    <= '0;
            tx_shift    <= '0;
            tx_idx      <= '0;
            o_data_a    <= '0;
            o_data_b    <= '0;
            o_op        <= '0;
            o_valid     <= 1'b0;
            o_tx_data   <= '0;
            o_tx_start  <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            sel         <= sel_nxt;
            staging     <= staging_nxt;
            byte_cnt    <= byte_cnt_nxt;
            tx_shift    <= tx_shift_nxt;
            tx_idx      <= tx_idx_nxt;
            o_data_a    <= data_a_nxt;
            o_data_b    <= data_b_nxt;
            o_op        <= op_nxt;
            o_valid     <= valid_nxt;
            o_tx_data   <= tx_data_nxt;
            o_tx_start  <= tx_start_nxt;
            o_frame_err <= frame_err_nxt;
            o_busy      <= (state_nxt != ST_IDLE);
        end
    end

endmodule
